// File: rtl/isp_cfg_ctrl.sv
// isp_cfg_ctrl: host-written staging bank copied into the active ISP bank at frame start, plus frame counter
module isp_cfg_ctrl #(
  parameter int BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                in_vsync,
  input  logic                cfg_req,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  output logic                cfg_ack,
  output logic [15:0]         cfg_rdata,
  output logic                dpc_en,
  output logic                blc_en,
  output logic                bnr_en,
  output logic                dgain_en,
  output logic [BITS-1:0]     dpc_threshold,
  output logic [BITS-1:0]     blc_r,
  output logic [BITS-1:0]     blc_gr,
  output logic [BITS-1:0]     blc_gb,
  output logic [BITS-1:0]     blc_b,
  output logic [BITS-1:0]     dgain_offset,
  output logic [3:0]          nr_level,
  output logic [7:0]          dgain_gain,
  output logic                commit_pending,
  output logic                cfg_applied,
  output logic [CNT_BITS-1:0] frame_cnt
);
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;
  typedef struct packed {
    logic [3:0]      en;
    logic [BITS-1:0] thr;
    logic [BITS-1:0] r;
    logic [BITS-1:0] gr;
    logic [BITS-1:0] gb;
    logic [BITS-1:0] b;
    logic [3:0]      nr;
    logic [7:0]      gain;
    logic [BITS-1:0] off;
  } bank_t;
  localparam bank_t RST = '{gain: 8'h10, default: '0};
  function automatic bank_t wr_bank(bank_t k, logic [3:0] a, logic [15:0] d);
    bank_t r;
    r = k;
    case (a)
      4'h0: r.en = d[3:0];
      4'h1: r.thr = d[BITS-1:0];
      4'h2: r.r = d[BITS-1:0];
      4'h3: r.gr = d[BITS-1:0];
      4'h4: r.gb = d[BITS-1:0];
      4'h5: r.b = d[BITS-1:0];
      4'h6: r.nr = d[3:0];
      4'h7: r.gain = d[7:0];
      4'h8: r.off = d[BITS-1:0];
      default: ;
    endcase
    return r;
  endfunction
  function automatic logic [15:0] rd_bank(bank_t k, logic [3:0] a);
    case (a)
      4'h0: return {12'b0, k.en};
      4'h1: return 16'(k.thr);
      4'h2: return 16'(k.r);
      4'h3: return 16'(k.gr);
      4'h4: return 16'(k.gb);
      4'h5: return 16'(k.b);
      4'h6: return {12'b0, k.nr};
      4'h7: return {8'b0, k.gain};
      4'h8: return 16'(k.off);
      default: return '0;
    endcase
  endfunction
  state_t state, state_nx;
  bank_t  stg, act;
  logic   vs_d, vs_rise, acc, wr;
  assign vs_rise = in_vsync & ~vs_d;
  // writes are held off while a commit is outstanding so staging stays frozen until applied
  assign acc = cfg_req & ~cfg_ack & (~cfg_we | state == IDLE);
  assign wr = acc & cfg_we;
  assign commit_pending = state != IDLE;
  assign {dgain_en, bnr_en, blc_en, dpc_en} = act.en;
  assign dpc_threshold = act.thr;
  assign blc_r = act.r;
  assign blc_gr = act.gr;
  assign blc_gb = act.gb;
  assign blc_b = act.b;
  assign nr_level = act.nr;
  assign dgain_gain = act.gain;
  assign dgain_offset = act.off;
  always_comb begin
    state_nx = state;
    if (state == APPLY) state_nx = IDLE;
    else if (state == PENDING && vs_rise) state_nx = APPLY;
    else if (wr && cfg_addr[3:0] == 4'hF) state_nx = cfg_wdata[0] ? APPLY : PENDING;
  end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= IDLE;
      vs_d <= 1'b0;
      frame_cnt <= '0;
      cfg_ack <= 1'b0;
      cfg_rdata <= '0;
      cfg_applied <= 1'b0;
      stg <= RST;
      act <= RST;
    end else begin
      state <= state_nx;
      vs_d <= in_vsync;
      frame_cnt <= frame_cnt + CNT_BITS'(vs_rise);
      cfg_ack <= acc;
      cfg_rdata <= (acc & ~cfg_we) ? (cfg_addr[3:0] == 4'hF ? {15'b0, commit_pending}
                                      : rd_bank(cfg_addr[4] ? act : stg, cfg_addr[3:0])) : '0;
      cfg_applied <= state == APPLY;
      if (state == APPLY) act <= stg;
      if (wr) stg <= wr_bank(stg, cfg_addr[3:0], cfg_wdata);
    end
  end
endmodule

// File: tb/tb_isp_cfg_ctrl.sv
// tb_isp_cfg_ctrl: directed and randomized checks of isp_cfg_ctrl against a register-map level model
module tb_isp_cfg_ctrl;
  localparam int BITS = 8;
  localparam int CB = 10;
  logic pclk, rst_n, in_vsync, cfg_req, cfg_we;
  logic [4:0] cfg_addr;
  logic [15:0] cfg_wdata, cfg_rdata;
  logic cfg_ack, dpc_en, blc_en, bnr_en, dgain_en, commit_pending, cfg_applied;
  logic [BITS-1:0] dpc_threshold, blc_r, blc_gr, blc_gb, blc_b, dgain_offset;
  logic [3:0] nr_level;
  logic [7:0] dgain_gain;
  logic [CB-1:0] frame_cnt;
  int total = 0, bad = 0;
  isp_cfg_ctrl #(.BITS(BITS), .CNT_BITS(CB)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .cfg_req(cfg_req), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .dpc_en(dpc_en), .blc_en(blc_en), .bnr_en(bnr_en), .dgain_en(dgain_en),
    .dpc_threshold(dpc_threshold), .blc_r(blc_r), .blc_gr(blc_gr), .blc_gb(blc_gb),
    .blc_b(blc_b), .dgain_offset(dgain_offset), .nr_level(nr_level), .dgain_gain(dgain_gain),
    .commit_pending(commit_pending), .cfg_applied(cfg_applied), .frame_cnt(frame_cnt)
  );
  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask
  // model: register-indexed staging/active arrays and commit bookkeeping
  int stg_m[9], act_m[9];
  bit pend_m, appl_m, ack_m, rd_m, applied_m, vs_prev_m, started;
  logic [15:0] rdata_m;
  int frame_m;
  function automatic int fmask(int a);
    return (a == 0 || a == 6) ? 'hF : (a == 7) ? 'hFF : (1 << BITS) - 1;
  endfunction
  always @(posedge pclk) begin
    bit rise, idle, acc, np, na;
    int a;
    started = 1;
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        stg_m[i] = (i == 7) ? 'h10 : 0;
        act_m[i] = stg_m[i];
      end
      pend_m = 0; appl_m = 0; ack_m = 0; rd_m = 0; applied_m = 0;
      vs_prev_m = 0; rdata_m = 0; frame_m = 0;
    end else begin
      rise = in_vsync && !vs_prev_m;
      idle = !pend_m && !appl_m;
      acc = cfg_req && !ack_m && (!cfg_we || idle);
      a = int'(cfg_addr[3:0]);
      np = pend_m;
      na = 0;
      rdata_m = 0;
      if (acc && !cfg_we)
        rdata_m = (a == 15) ? 16'(pend_m | appl_m) : (a <= 8) ? 16'(cfg_addr[4] ? act_m[a] : stg_m[a]) : 16'h0;
      applied_m = appl_m;
      if (appl_m) act_m = stg_m;
      if (pend_m && rise) begin
        np = 0;
        na = 1;
      end
      if (acc && cfg_we) begin
        if (a == 15) begin
          if (cfg_wdata[0]) na = 1;
          else np = 1;
        end else if (a <= 8) stg_m[a] = int'(cfg_wdata) & fmask(a);
      end
      pend_m = np;
      appl_m = na;
      ack_m = acc;
      rd_m = acc && !cfg_we;
      frame_m = (frame_m + int'(rise)) % (1 << CB);
      vs_prev_m = in_vsync;
    end
  end
  always @(negedge pclk) begin
    if (started) begin
      chk("ack", cfg_ack, ack_m);
      if (ack_m && rd_m) chk("rdata", cfg_rdata, rdata_m);
      chk("enables", {dgain_en, bnr_en, blc_en, dpc_en}, act_m[0]);
      chk("dpc_threshold", dpc_threshold, act_m[1]);
      chk("blc_r", blc_r, act_m[2]);
      chk("blc_gr", blc_gr, act_m[3]);
      chk("blc_gb", blc_gb, act_m[4]);
      chk("blc_b", blc_b, act_m[5]);
      chk("nr_level", nr_level, act_m[6]);
      chk("dgain_gain", dgain_gain, act_m[7]);
      chk("dgain_offset", dgain_offset, act_m[8]);
      chk("commit_pending", commit_pending, pend_m | appl_m);
      chk("cfg_applied", cfg_applied, applied_m);
      chk("frame_cnt", frame_cnt, frame_m);
    end
  end
  task automatic access(input bit we, input logic [4:0] a, input logic [15:0] d, output logic [15:0] q);
    cfg_req = 1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    for (int n = 0; n < 1000; n++) begin
      @(negedge pclk);
      if (cfg_ack) break;
    end
    if (cfg_ack !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_timeout addr=%0h got=%b exp=1", a, cfg_ack);
    end
    q = cfg_rdata;
    cfg_req = 0;
  endtask
  task automatic rd_chk(input string n, input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] q;
    access(0, a, 16'h0, q);
    chk(n, q, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    logic [15:0] q;
    access(1, a, d, q);
  endtask
  task automatic vs_pulse();
    in_vsync = 1;
    @(negedge pclk);
    in_vsync = 0;
  endtask
  bit rand_done;
  initial begin
    logic [15:0] q;
    logic [4:0] a;
    rst_n = 0; in_vsync = 0; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    repeat (3) @(negedge pclk);
    rst_n = 1;
    chk("rst_gain", dgain_gain, 'h10);
    chk("rst_en", {dgain_en, bnr_en, blc_en, dpc_en}, 0);
    chk("rst_rdata", cfg_rdata, 0);
    rd_chk("rd_act_gain", 5'h17, 16'h0010);
    rd_chk("rd_act_en", 5'h10, 16'h0000);
    wr(5'h01, 16'h003C);
    wr(5'h0F, 16'h0000);
    chk("pend_after_commit", commit_pending, 1);
    in_vsync = 1;
    @(negedge pclk);
    in_vsync = 0;
    chk("thr_before_apply", dpc_threshold, 0);
    @(negedge pclk);
    chk("thr_applied", dpc_threshold, 'h3C);
    chk("applied_pulse", cfg_applied, 1);
    @(negedge pclk);
    chk("applied_single", cfg_applied, 0);
    rd_chk("rd_act_thr", 5'h11, 16'h003C);
    wr(5'h0F, 16'h0000);
    fork
      wr(5'h00, 16'h000F);
      begin
        repeat (6) begin
          @(negedge pclk);
          chk("stall_no_ack", cfg_ack, 0);
        end
        vs_pulse();
      end
    join
    chk("en_unchanged", {dgain_en, bnr_en, blc_en, dpc_en}, 0);
    rd_chk("rd_stg_en", 5'h00, 16'h000F);
    rd_chk("rd_act_en2", 5'h10, 16'h0000);
    wr(5'h02, 16'h0055);
    @(negedge pclk);
    in_vsync = 1;
    wr(5'h0F, 16'h0000);
    in_vsync = 0;
    repeat (4) @(negedge pclk);
    chk("same_cycle_pending", commit_pending, 1);
    chk("same_cycle_blc_r", blc_r, 0);
    vs_pulse();
    @(negedge pclk);
    chk("next_frame_blc_r", blc_r, 'h55);
    chk("next_frame_applied", cfg_applied, 1);
    wr(5'h07, 16'h0020);
    wr(5'h0F, 16'h0001);
    chk("forced_gain_before", dgain_gain, 'h10);
    @(negedge pclk);
    chk("forced_gain", dgain_gain, 'h20);
    chk("forced_frame", frame_cnt, 4);
    repeat (1020) begin
      vs_pulse();
      @(negedge pclk);
    end
    chk("frame_wrap", frame_cnt, 0);
    wr(5'h0F, 16'h0000);
    chk("pend_before_rst", commit_pending, 1);
    rst_n = 0;
    @(negedge pclk);
    rst_n = 1;
    chk("rst_pending", commit_pending, 0);
    chk("rst_thr", dpc_threshold, 0);
    chk("rst_gain2", dgain_gain, 'h10);
    chk("rst_blc_r", blc_r, 0);
    chk("rst_frame", frame_cnt, 0);
    @(negedge pclk);
    rand_done = 0;
    fork
      begin
        repeat (300) begin
          repeat ($urandom_range(0, 2)) @(negedge pclk);
          a = ($urandom_range(0, 7) == 0) ? 5'h0F : 5'($urandom);
          access($urandom_range(0, 1) == 1, a, 16'($urandom), q);
        end
        rand_done = 1;
      end
      while (!rand_done) begin
        @(negedge pclk);
        if ($urandom_range(0, 4) == 0) in_vsync = ~in_vsync;
      end
    join
    in_vsync = 0;
    repeat (5) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
